// File: rtl/rc4_keystream_arb_if.sv
// Consumer-side bus of the rc4 keystream arbiter.
//   req0/req1 : requesters each want one keystream byte
//   ack0/ack1 : one-cycle grant pulse, at most one high per cycle
//   ks_byte   : granted keystream byte, valid together with the ack
// Modports: master = a requester pair, slave = the arbiter.
interface rc4_keystream_arb_if;
  logic       req0;
  logic       req1;
  logic       ack0;
  logic       ack1;
  logic [7:0] ks_byte;

  modport master (output req0, req1, input ack0, ack1, ks_byte);
  modport slave  (input req0, req1, output ack0, ack1, ks_byte);
endinterface

// File: rtl/rc4_keystream_arb.sv
// Controller and arbiter for the rc4 PRGA core.
// Buffers a host-loaded key, walks the core through reset and byte-serial
// key injection, captures every valid keystream byte into a FIFO and hands
// bytes to two consumers through a round-robin request/acknowledge arbiter.
// The core cannot be stalled: a byte arriving at a full FIFO with no pop in
// the same cycle is dropped and the sticky overrun flag is raised.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_wr, key_byte      append a byte to the key buffer (IDLE/RUN only)
//   key_start             (re)start keying with the buffered key
//   busy                  high while in CRST or FEED
//   overrun               sticky: a keystream byte was dropped
//   core_rst, core_key    reset and password_input of the rc4 core
//   core_ready, core_k    output_ready and K of the rc4 core
//   cons                  consumer bus (rc4_keystream_arb_if.slave)
//
// Build option: define RC4_ARB_FIXED_PRIO_EN to make req0 always win
// contention (no round-robin pointer is kept).
module rc4_keystream_arb #(
  parameter int KEY_SIZE   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_wr,
  input  logic [7:0]         key_byte,
  input  logic               key_start,
  output logic               busy,
  output logic               overrun,
  output logic               core_rst,
  output logic [7:0]         core_key,
  input  logic               core_ready,
  input  logic [7:0]         core_k,
  rc4_keystream_arb_if.slave cons
);
  localparam int KW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
  localparam int CW = $clog2(KEY_SIZE + 1);
  localparam int FW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CRST, FEED, RUN} state_e;

  state_e        state_q;
  logic          crst_cnt_q;
  logic [CW-1:0] feed_cnt_q;
  logic [KW-1:0] key_wptr_q, key_wptr_d;
  logic [FW:0]   wr_ptr_q, rd_ptr_q;
  logic          core_rst_q, overrun_q, ack0_q, ack1_q;
  logic [7:0]    ks_byte_q;

  logic [7:0] key_mem  [KEY_SIZE];
  logic [7:0] fifo_mem [FIFO_DEPTH];

  logic key_open, start_ok, run, fifo_empty, fifo_full;
  logic pop, push, drop, grant1;

  assign key_open = (state_q == IDLE) || (state_q == RUN);
  assign start_ok = key_open && key_start;
  // A restart flushes the FIFO, so neither push nor pop happens that cycle.
  assign run      = (state_q == RUN) && !key_start;

  assign key_wptr_d = (key_wptr_q == KW'(KEY_SIZE - 1)) ? '0 : key_wptr_q + KW'(1);

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FW] != rd_ptr_q[FW]) &&
                      (wr_ptr_q[FW-1:0] == rd_ptr_q[FW-1:0]);

  assign pop  = run && !fifo_empty && (cons.req0 || cons.req1);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push = run && core_ready && (!fifo_full || pop);
  assign drop = run && core_ready && fifo_full && !pop;

`ifdef RC4_ARB_FIXED_PRIO_EN
  assign grant1 = !cons.req0;
`else
  logic prio1_q;  // 1: req1 wins the next contention

  assign grant1 = cons.req1 && (!cons.req0 || prio1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio1_q <= 1'b0;
    else if (pop) prio1_q <= !grant1;
  end
`endif

  // core_key follows the feed counter combinationally so the core sees byte c
  // in the same cycle the counter holds c.
  always_comb begin
    // NOTE: default assignment first, so no path leaves core_key unassigned
    // and no latch is inferred.
    core_key = 8'h00;
    if ((state_q == FEED) && (feed_cnt_q < CW'(KEY_SIZE)))
      core_key = key_mem[feed_cnt_q[KW-1:0]];
  end

  // NOTE: the key buffer and FIFO storage carry no reset; validity is tracked
  // by the pointers, and the key must survive rst_n.
  always_ff @(posedge clk) begin
    if (key_open && key_wr) key_mem[key_wptr_q] <= key_byte;
    if (push) fifo_mem[wr_ptr_q[FW-1:0]] <= core_k;
  end

  // NOTE: sequential state uses non-blocking assignments only; a later
  // assignment in this block intentionally overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      crst_cnt_q <= 1'b0;
      feed_cnt_q <= '0;
      key_wptr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      core_rst_q <= 1'b1;
      overrun_q  <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      ks_byte_q  <= 8'h00;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;

      if (key_open && key_wr) key_wptr_q <= key_wptr_d;

      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + (FW + 1)'(1);
        ks_byte_q <= fifo_mem[rd_ptr_q[FW-1:0]];
        if (grant1) ack1_q <= 1'b1;
        else        ack0_q <= 1'b1;
      end
      if (push) wr_ptr_q  <= wr_ptr_q + (FW + 1)'(1);
      if (drop) overrun_q <= 1'b1;

      case (state_q)
        IDLE, RUN: begin
          if (start_ok) begin
            state_q    <= CRST;
            crst_cnt_q <= 1'b0;
            core_rst_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overrun_q  <= 1'b0;
            key_wptr_q <= '0;
          end
        end
        CRST: begin
          if (crst_cnt_q) begin
            state_q    <= FEED;
            core_rst_q <= 1'b0;
            feed_cnt_q <= '0;
          end else begin
            crst_cnt_q <= 1'b1;
          end
        end
        FEED: begin
          if (feed_cnt_q == CW'(KEY_SIZE)) state_q <= RUN;
          else feed_cnt_q <= feed_cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q == CRST) || (state_q == FEED);
  assign overrun      = overrun_q;
  assign core_rst     = core_rst_q;
  assign cons.ack0    = ack0_q;
  assign cons.ack1    = ack1_q;
  assign cons.ks_byte = ks_byte_q;
endmodule

// File: tb/tb_rc4_keystream_arb.sv
// Bench for rc4_keystream_arb. A behavioural stand-in for the rc4 core
// captures the injected key and plays back the software RC4 keystream
// (offset 1536) with random gaps; a queue-based model of the controller
// predicts every output each cycle.
module tb_rc4_keystream_arb;
  localparam int KS    = 16;
  localparam int DEPTH = 8;
  localparam int NGEN  = 160;

  logic       clk, rst_n, key_wr, key_start, busy, overrun, core_rst, core_ready;
  logic [7:0] key_byte, core_key, core_k;

  rc4_keystream_arb_if bus ();

  rc4_keystream_arb #(.KEY_SIZE(KS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .key_wr(key_wr), .key_byte(key_byte),
    .key_start(key_start), .busy(busy), .overrun(overrun),
    .core_rst(core_rst), .core_key(core_key), .core_ready(core_ready),
    .core_k(core_k), .cons(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- software RC4 ----------------
  byte unsigned core_q[$];
  byte unsigned ref_q[$];

  task automatic rc4_gen(input byte unsigned k [KS], input int n, input bit to_ref);
    byte unsigned s [256];
    byte unsigned t;
    int i, j;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + int'(s[x]) + int'(k[x % KS])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    if (to_ref) ref_q.delete(); else core_q.delete();
    i = 0; j = 0;
    for (int x = 0; x < 1536 + n; x++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (x >= 1536) begin
        t = s[(int'(s[i]) + int'(s[j])) % 256];
        if (to_ref) ref_q.push_back(t); else core_q.push_back(t);
      end
    end
  endtask

  // ---------------- core stand-in ----------------
  byte unsigned cap_key [KS];
  int cap_n = 0;
  int stream_idx = 0;
  int emit_limit = 1000;

  initial begin
    int st_delay, gap;
    core_ready = 1'b0;
    core_k     = 8'h00;
    st_delay   = 0;
    gap        = 0;
    forever begin
      @(posedge clk);
      #1;
      core_ready = 1'b0;
      if (core_rst) begin
        cap_n = 0;
        core_q.delete();
      end else if (cap_n < KS) begin
        cap_key[cap_n] = core_key;
        cap_n++;
        if (cap_n == KS) begin
          rc4_gen(cap_key, NGEN, 1'b0);
          stream_idx = 0;
          st_delay   = int'($urandom_range(5, 12));
          gap        = 0;
        end
      end else if (st_delay > 0) begin
        st_delay--;
      end else if (gap > 0) begin
        gap--;
      end else if (core_q.size() > 0 && stream_idx < emit_limit) begin
        core_ready = 1'b1;
        core_k     = core_q.pop_front();
        stream_idx++;
        gap = int'($urandom_range(1, 3));
      end
    end
  end

  // ---------------- controller model ----------------
  byte unsigned mq[$];
  byte unsigned m_key [KS];
  int   m_mode, m_since, m_kwp, m_pops, busy_seen;
  bit   m_over, m_last1, e_ack0, e_ack1;
  logic [7:0] e_ks;
  byte unsigned got_q[$];

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_since = 0; m_kwp = 0;
    m_over = 1'b0; m_last1 = 1'b1;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_ks = 8'h00;
  endtask

  task automatic compare_all();
    int c;
    logic [7:0] exp_key;
    c = m_since - 2;
    exp_key = (m_mode == 1 && c >= 0 && c < KS) ? m_key[c] : 8'h00;
    check("ack0", 32'(bus.ack0), 32'(e_ack0));
    check("ack1", 32'(bus.ack1), 32'(e_ack1));
    check("ks_byte", 32'(bus.ks_byte), 32'(e_ks));
    check("overrun", 32'(overrun), 32'(m_over));
    check("busy", 32'(busy), 32'(m_mode == 1));
    check("core_rst", 32'(core_rst), 32'(m_mode == 0 || (m_mode == 1 && m_since < 2)));
    check("core_key", 32'(core_key), 32'(exp_key));
    if (bus.ack0 || bus.ack1) got_q.push_back(bus.ks_byte);
    if (busy) busy_seen++;
  endtask

  // One clock: update the model from the inputs seen at the edge, then
  // compare on the falling edge.
  task automatic step();
    bit w1;
    @(posedge clk);
    e_ack0 = 1'b0;
    e_ack1 = 1'b0;
    if (key_wr && m_mode != 1) begin
      m_key[m_kwp] = key_byte;
      m_kwp = (m_kwp + 1) % KS;
    end
    if (key_start && m_mode != 1) begin
      mq.delete();
      m_over = 1'b0; m_kwp = 0; m_mode = 1; m_since = 0;
    end else if (m_mode == 1) begin
      m_since++;
      if (m_since == KS + 3) m_mode = 2;
    end else if (m_mode == 2) begin
      if (mq.size() != 0 && (bus.req0 || bus.req1)) begin
`ifdef RC4_ARB_FIXED_PRIO_EN
        w1 = !bus.req0;
`else
        if (bus.req0 && bus.req1) w1 = !m_last1;
        else w1 = bus.req1;
`endif
        m_last1 = w1;
        e_ks = mq.pop_front();
        if (w1) e_ack1 = 1'b1; else e_ack0 = 1'b1;
        m_pops++;
      end
      if (core_ready) begin
        if (mq.size() < DEPTH) mq.push_back(core_k);
        else m_over = 1'b1;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic load_key(input byte unsigned k [KS]);
    for (int i = 0; i < KS; i++) begin
      key_wr = 1'b1;
      key_byte = k[i];
      step();
    end
    key_wr = 1'b0;
  endtask

  task automatic do_keying(input byte unsigned k [KS]);
    busy_seen = 0;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    repeat (KS + 3) step();
    check("busy_len", 32'(busy_seen), 32'(KS + 3));
    for (int i = 0; i < KS; i++) check("cap_key", 32'(cap_key[i]), 32'(k[i]));
  endtask

  task automatic run_pops(input int n, input int budget);
    int target, k;
    target = m_pops + n;
    k = 0;
    while (m_pops < target && k < budget) begin
      step();
      k++;
    end
    check("pops", 32'(m_pops), 32'(target));
  endtask

  task automatic wait_idx(input int target, input int budget);
    int k;
    k = 0;
    while (stream_idx < target && k < budget) begin
      step();
      k++;
    end
    check("emitted", 32'(stream_idx), 32'(target));
  endtask

  task automatic compare_stream(input string tag, input int base, input int n);
    check({tag, "_n"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(ref_q[base + i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte unsigned key1 [KS];
    byte unsigned key2 [KS];
    int base, k;
    for (int i = 0; i < KS; i++) begin
      key1[i] = 8'(i + 1);
      key2[i] = 8'(8'hFF - i);
    end
    for (int i = 0; i < KS; i++) m_key[i] = 8'h00;
    m_pops = 0; busy_seen = 0;
    rst_n = 1'b1; key_wr = 1'b0; key_byte = 8'h00; key_start = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Key 0x01..0x10, req0 only.
    rc4_gen(key1, NGEN, 1'b1);
    load_key(key1);
    do_keying(key1);
    got_q.delete();
    bus.req0 = 1'b1;
    run_pops(16, 400);
    compare_stream("ks_key1", 0, 16);

    // Both requesters held: alternating grants, no gaps or duplicates.
    got_q.delete();
    bus.req1 = 1'b1;
    run_pops(16, 400);
    compare_stream("ks_both", 16, 16);

    // Drain, then 20 bytes with no requests: first 8 kept, rest dropped.
    emit_limit = stream_idx;
    repeat (6) step();
    base = stream_idx;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    emit_limit = base + 20;
    wait_idx(base + 20, 300);
    repeat (4) step();
    check("overrun_set", 32'(overrun), 32'd1);
    got_q.delete();
    bus.req0 = 1'b1;
    run_pops(8, 50);
    compare_stream("ks_drop", base, 8);
    repeat (6) step();

    // Random requests against the model.
    emit_limit = 1000;
    for (int i = 0; i < 150; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      step();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // New key written during RUN, restart, fill, request on a ready cycle.
    emit_limit = 0;
    rc4_gen(key2, NGEN, 1'b1);
    load_key(key2);
    emit_limit = 8;
    do_keying(key2);
    check("overrun_clr", 32'(overrun), 32'd0);
    wait_idx(8, 300);
    repeat (4) step();
    emit_limit = 9;
    k = 0;
    while (core_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    check("ready_seen", 32'(core_ready), 32'd1);
    got_q.delete();
    bus.req0 = 1'b1;
    run_pops(9, 200);
    compare_stream("ks_key2", 0, 9);
    check("full_push_no_overrun", 32'(overrun), 32'd0);
    bus.req0 = 1'b0;

    // Reset during FEED, then a clean restart with the retained key.
    emit_limit = 1000;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    repeat (6) step();
    check("in_feed", 32'(busy), 32'd1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    repeat (3) step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    do_keying(key2);
    got_q.delete();
    bus.req0 = 1'b1;
    run_pops(8, 300);
    compare_stream("ks_after_rst", 0, 8);
    bus.req0 = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/rc4_keystream_arb.md
# rc4_keystream_arb

Controller and arbiter for the rc4 PRGA core. Holds a host-loaded key, sequences the core through reset and byte-serial key injection, and captures each valid keystream byte into a small FIFO. Two consumers share the single keystream through a round-robin request/acknowledge arbiter. The core cannot be stalled, so unconsumed bytes beyond FIFO capacity are dropped and flagged.

## Interface

- `KEY_SIZE`, default 16: key length in bytes; must match the core's `KEY_SIZE`.
- `FIFO_DEPTH`, default 8: keystream FIFO entries; power of two, at least 2.
- `clk` in, 1 bit: clock.
- `rst_n` in, 1 bit: reset, asynchronous, active-low.
- `key_wr` in, 1 bit: write `key_byte` into the key buffer.
- `key_byte` in, 8 bits: key data.
- `key_start` in, 1 bit: start or restart keying with the buffered key.
- `busy` out, 1 bit: high in `CRST` and `FEED`.
- `overrun` out, 1 bit: sticky flag; a keystream byte was dropped.
- `core_rst` out, 1 bit: active-high reset to the rc4 core.
- `core_key` out, 8 bits: drives the core's `password_input`.
- `core_ready` in, 1 bit: the core's `output_ready`.
- `core_k` in, 8 bits: the core's `K`.
- `req0` / `req1` in, 1 bit each: requester wants one byte.
- `ack0` / `ack1` out, 1 bit each: one-cycle grant; `ks_byte` is valid in the same cycle.
- `ks_byte` out, 8 bits: granted keystream byte, registered.

## Operation

- States: `IDLE`, `CRST`, `FEED`, `RUN`.
- Reset values:
  - state `IDLE`.
  - `core_rst` = 1.
  - `core_key`, `ks_byte`, `ack0`, `ack1`, `overrun`, `busy` = 0.
  - FIFO empty; key write pointer 0; round-robin pointer favours `req0`.
- Key buffer:
  - In `IDLE` or `RUN`, `key_wr` stores `key_byte` at the write pointer, then increments the pointer. The pointer wraps at `KEY_SIZE`.
  - `key_wr` is ignored in `CRST` and `FEED`.
  - Writing in `RUN` does not affect the running keystream.
- `key_start` in `IDLE` or `RUN`:
  - next state `CRST`.
  - flush FIFO, clear `overrun`, reset key write pointer to 0.
  - `key_start` is ignored in `CRST` and `FEED`.
- `CRST`:
  - `core_rst` = 1 for 2 cycles, then `FEED`.
- `FEED`:
  - `core_rst` = 0; counter c runs 0..`KEY_SIZE`.
  - For c < `KEY_SIZE`, `core_key` = `key[c]`, combinational from c. The core captures byte c on the c-th clock after reset release.
  - At c = `KEY_SIZE`, `core_key` = 0 and the next state is `RUN`.
- `RUN`:
  - Each cycle with `core_ready` = 1 pushes `core_k` into the FIFO.
  - The core already discards its first 1536 bytes, so every `core_ready` byte is valid.
  - `core_ready` is never high on consecutive cycles.
- Push and pop in the same cycle: both happen, and occupancy is unchanged.
- FIFO full:
  - Full + push + pop in the same cycle: the push is accepted.
  - Full + push with no pop: the byte is dropped and `overrun` is set to 1 until the next `key_start`.
- Arbitration, `RUN` only:
  - Requires the FIFO non-empty and `req0`|`req1` high.
  - Pop one byte into `ks_byte`; pulse the winner's ack.
  - If both request, the winner is the requester not granted last; the pointer updates on every grant.
  - At most one ack per cycle.
  - A requester holding req high is re-eligible on the next cycle.
- FIFO empty: no ack, regardless of req.
- In `IDLE`/`CRST`/`FEED`: no acks, and `core_ready` is ignored.

## Timing

- `key_start` sampled at edge T:
  - `core_rst` high for T+1..T+2.
  - `FEED` for `KEY_SIZE`+1 cycles.
  - `RUN` from T+3+`KEY_SIZE`.
- The first `core_ready` arrives about 3850 cycles after `RUN` entry. This is set by the core's schedule and discard, not by this block.
- Grant latency: if req is high and the FIFO is non-empty at edge E, ack and `ks_byte` are visible after E. The byte pushed at E is poppable at E+1.
- Sustained throughput is 1 byte per 2 cycles, limited by the core.
- Deasserting `rst_n` mid-operation asynchronously returns all state to its reset values. The key buffer contents are not reset.

## Configuration

- `RC4_ARB_FIXED_PRIO_EN`:
  - Defined: `req0` always wins contention; no round-robin pointer is kept.
  - Undefined (default): round-robin as described above.

## Test plan

- Load key 0x01..0x10 with `KEY_SIZE`=16, pulse `key_start`, hold `req0` → `ack0` byte sequence equals a software RC4 model of that key at keystream offset 1536; no `overrun`.
- Hold both `req0` and `req1` in `RUN` → acks alternate 0,1,0,1; the concatenated bytes match the model with no gaps or duplicates. With `RC4_ARB_FIXED_PRIO_EN` defined → only `ack0` pulses.
- Hold no requests for 20 core bytes with `FIFO_DEPTH`=8 → FIFO holds bytes 0..7, `overrun`=1, and the next 8 acks return bytes 0..7.
- Raise a request exactly on a `core_ready` cycle with the FIFO full → the push is accepted, `overrun` stays 0, and ordering is preserved.
- Pulse `key_start` mid-`RUN` with a new key 0xFF..0xF0 → FIFO flushed, `overrun`=0, `busy`=1 for `KEY_SIZE`+3 cycles, and the stream matches the model for the new key.
- Drop `rst_n` during `FEED` → `core_rst`=1, no acks, `IDLE`; a subsequent `key_start` produces the correct stream.
